// File: rtl/game_flow_pkg.sv
// Shared definitions for the game-flow controller: state encoding and keycodes.
package game_flow_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_INTRO    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_RESPAWN  = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_GAMEOVER = 3'd5,
    ST_WIN      = 3'd6
  } state_e;

  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC   = 8'h29;

endpackage

// File: rtl/key_edge_detect.sv
// Single-key press detector: pulses for one cycle when keycode first equals KEY,
// so a held key yields exactly one event.
module key_edge_detect
  import game_flow_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_ENTER
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       press
);

  logic [7:0] prev_keycode_q;
  logic [7:0] prev_keycode_d;

  // Previous keycode is captured unconditionally every cycle.
  always_comb begin
    prev_keycode_d = keycode;
  end

  // Key history register, cleared by reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) prev_keycode_q <= '0;
    else       prev_keycode_q <= prev_keycode_d;
  end

  assign press = (keycode == KEY) && (prev_keycode_q != KEY);

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game-flow FSM: start screen, level intro, play, respawn, pause,
// game over and win, tracking level index, lives and a frame timer.
module game_flow_controller
  import game_flow_pkg::*;
#(
  parameter int unsigned NUM_LEVELS     = 3,
  parameter int unsigned LIVES          = 3,
  parameter logic [7:0]  START_KEY      = KEY_ENTER,
  parameter logic [7:0]  PAUSE_KEY      = KEY_ESC,
  parameter int unsigned INTRO_FRAMES   = 120,
  parameter int unsigned RESPAWN_FRAMES = 60,
  localparam int unsigned LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int unsigned LIFE_W = $clog2(LIVES + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic [7:0]        keycode,
  input  logic              died,
  input  logic              level_cleared,
  output logic              start,
  output logic              intro,
  output logic              play,
  output logic              respawn,
  output logic              paused,
  output logic              gameover,
  output logic              win,
  output logic              boss_level,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic              level_start
);

  localparam int unsigned TMR_MAX = (INTRO_FRAMES > RESPAWN_FRAMES) ? INTRO_FRAMES : RESPAWN_FRAMES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [LVL_W-1:0]  LAST_LVL     = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT   = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] LIFE_ONE     = LIFE_W'(1);
  localparam logic [TMR_W-1:0]  INTRO_INIT   = TMR_W'(INTRO_FRAMES);
  localparam logic [TMR_W-1:0]  RESPAWN_INIT = TMR_W'(RESPAWN_FRAMES);
  localparam logic [TMR_W-1:0]  TMR_ONE      = TMR_W'(1);

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               level_start_q, level_start_d;

  logic start_press;
  logic pause_press;

  key_edge_detect #(.KEY(START_KEY)) u_start_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (start_press)
  );

  key_edge_detect #(.KEY(PAUSE_KEY)) u_pause_key (
    .Clk     (Clk),
    .Reset   (Reset),
    .keycode (keycode),
    .press   (pause_press)
  );

  // Next-state, level/lives/timer updates and the level_start pulse request.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    lives_d       = lives_q;
    timer_d       = timer_q;
    level_start_d = 1'b0;
    case (state_q)
      ST_START: begin
        if (start_press) begin
          state_d = ST_INTRO;
          level_d = '0;
          lives_d = LIVES_INIT;
          timer_d = INTRO_INIT;
        end
      end
      ST_INTRO: begin
        if (start_press) begin
          state_d       = ST_PLAY;
          timer_d       = '0;
          level_start_d = 1'b1;
        end else if (frame_tick && (timer_q != '0)) begin
          if (timer_q == TMR_ONE) begin
            state_d       = ST_PLAY;
            timer_d       = '0;
            level_start_d = 1'b1;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      ST_PLAY: begin
        if (died) begin
          lives_d = lives_q - LIFE_ONE;
          if (lives_q == LIFE_ONE) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d = ST_RESPAWN;
            timer_d = RESPAWN_INIT;
          end
        end else if (level_cleared) begin
          if (level_q == LAST_LVL) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_INTRO;
            level_d = level_q + LVL_W'(1);
            timer_d = INTRO_INIT;
          end
        end else if (pause_press) begin
          state_d = ST_PAUSE;
        end
      end
      ST_RESPAWN: begin
        if (frame_tick && (timer_q != '0)) begin
          if (timer_q == TMR_ONE) begin
            state_d = ST_PLAY;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TMR_ONE;
          end
        end
      end
      ST_PAUSE: begin
        if (pause_press) state_d = ST_PLAY;
      end
      ST_GAMEOVER, ST_WIN: begin
        if (start_press) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  // State, counters and level_start pulse registers with async reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_START;
      level_q       <= '0;
      lives_q       <= LIVES_INIT;
      timer_q       <= '0;
      level_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      lives_q       <= lives_d;
      timer_q       <= timer_d;
      level_start_q <= level_start_d;
    end
  end

  // Moore flag decode from the state register: exactly one flag high.
  always_comb begin
    start    = 1'b0;
    intro    = 1'b0;
    play     = 1'b0;
    respawn  = 1'b0;
    paused   = 1'b0;
    gameover = 1'b0;
    win      = 1'b0;
    case (state_q)
      ST_START:    start    = 1'b1;
      ST_INTRO:    intro    = 1'b1;
      ST_PLAY:     play     = 1'b1;
      ST_RESPAWN:  respawn  = 1'b1;
      ST_PAUSE:    paused   = 1'b1;
      ST_GAMEOVER: gameover = 1'b1;
      ST_WIN:      win      = 1'b1;
      default:     start    = 1'b1;
    endcase
  end

  assign level       = level_q;
  assign lives       = lives_q;
  assign boss_level  = (level_q == LAST_LVL);
  assign level_start = level_start_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed testbench for game_flow_controller (NUM_LEVELS=3, LIVES=3,
// INTRO_FRAMES=4, RESPAWN_FRAMES=3).
module tb_game_flow_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [7:0] keycode;
  logic       died;
  logic       level_cleared;
  logic       start, intro, play, respawn, paused, gameover, win;
  logic       boss_level;
  logic [1:0] level;
  logic [1:0] lives;
  logic       level_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Flag vector order: {start, intro, play, respawn, paused, gameover, win}
  localparam logic [6:0] F_START = 7'b1000000;
  localparam logic [6:0] F_INTRO = 7'b0100000;
  localparam logic [6:0] F_PLAY  = 7'b0010000;
  localparam logic [6:0] F_RESP  = 7'b0001000;
  localparam logic [6:0] F_PAUSE = 7'b0000100;
  localparam logic [6:0] F_OVER  = 7'b0000010;
  localparam logic [6:0] F_WIN   = 7'b0000001;

  localparam logic [7:0] ENTER = 8'h28;
  localparam logic [7:0] ESC   = 8'h29;

  game_flow_controller #(
    .NUM_LEVELS     (3),
    .LIVES          (3),
    .START_KEY      (8'h28),
    .PAUSE_KEY      (8'h29),
    .INTRO_FRAMES   (4),
    .RESPAWN_FRAMES (3)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_tick    (frame_tick),
    .keycode       (keycode),
    .died          (died),
    .level_cleared (level_cleared),
    .start         (start),
    .intro         (intro),
    .play          (play),
    .respawn       (respawn),
    .paused        (paused),
    .gameover      (gameover),
    .win           (win),
    .boss_level    (boss_level),
    .level         (level),
    .lives         (lives),
    .level_start   (level_start)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] flags();
    return {start, intro, play, respawn, paused, gameover, win};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [6:0] ef, input int el, input int ev, input logic els);
    chk({tag, ".flags"}, 32'(flags()), 32'(ef));
    chk({tag, ".level"}, 32'(level), 32'(el));
    chk({tag, ".lives"}, 32'(lives), 32'(ev));
    chk({tag, ".level_start"}, 32'(level_start), 32'(els));
  endtask

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
  endtask

  task automatic key_on(input logic [7:0] k);
    keycode = k;
    clk1();
  endtask

  task automatic key_off();
    keycode = 8'h00;
    clk1();
  endtask

  task automatic pulse_died();
    died = 1'b1;
    clk1();
    died = 1'b0;
  endtask

  task automatic pulse_clear();
    level_cleared = 1'b1;
    clk1();
    level_cleared = 1'b0;
  endtask

  initial begin
    Reset         = 1'b1;
    frame_tick    = 1'b0;
    keycode       = 8'h00;
    died          = 1'b0;
    level_cleared = 1'b0;
    clk1();
    clk1();
    st("reset", F_START, 0, 3, 1'b0);
    chk("reset.boss", 32'(boss_level), 32'd0);
    Reset = 1'b0;
    clk1();
    st("idle_start", F_START, 0, 3, 1'b0);

    // Enter held 10 cycles: one advance only
    key_on(ENTER);
    st("enter_to_intro", F_INTRO, 0, 3, 1'b0);
    for (int i = 0; i < 9; i++) clk1();
    st("enter_held", F_INTRO, 0, 3, 1'b0);
    key_off();
    st("enter_released", F_INTRO, 0, 3, 1'b0);
    frame(); frame(); frame();
    st("intro_3_ticks", F_INTRO, 0, 3, 1'b0);
    frame();
    st("intro_expire", F_PLAY, 0, 3, 1'b1);
    clk1();
    st("level_start_drop", F_PLAY, 0, 3, 1'b0);

    // Deaths through respawn down to game over
    pulse_died();
    st("died1", F_RESP, 0, 2, 1'b0);
    key_on(ENTER);
    key_off();
    died = 1'b1;
    level_cleared = 1'b1;
    clk1();
    died = 1'b0;
    level_cleared = 1'b0;
    st("respawn_ignores", F_RESP, 0, 2, 1'b0);
    frame(); frame();
    st("respawn_2_ticks", F_RESP, 0, 2, 1'b0);
    frame();
    st("respawn_expire", F_PLAY, 0, 2, 1'b0);
    pulse_died();
    st("died2", F_RESP, 0, 1, 1'b0);
    frame(); frame(); frame();
    st("respawn2_expire", F_PLAY, 0, 1, 1'b0);
    pulse_died();
    st("died3_gameover", F_OVER, 0, 0, 1'b0);
    pulse_clear();
    st("gameover_hold", F_OVER, 0, 0, 1'b0);
    key_on(ENTER);
    st("gameover_to_start", F_START, 0, 0, 1'b0);
    key_off();
    key_on(ENTER);
    st("restart_intro", F_INTRO, 0, 3, 1'b0);
    key_off();

    // Level progression with Enter skipping intros
    key_on(ENTER);
    st("skip_intro0", F_PLAY, 0, 3, 1'b1);
    key_off();
    pulse_clear();
    st("clear0", F_INTRO, 1, 3, 1'b0);
    chk("clear0.boss", 32'(boss_level), 32'd0);
    key_on(ENTER);
    st("skip_intro1", F_PLAY, 1, 3, 1'b1);
    key_off();
    pulse_clear();
    st("clear1", F_INTRO, 2, 3, 1'b0);
    chk("clear1.boss", 32'(boss_level), 32'd1);
    key_on(ENTER);
    key_off();
    st("boss_play", F_PLAY, 2, 3, 1'b0);

    // died has priority over level_cleared
    died = 1'b1;
    level_cleared = 1'b1;
    clk1();
    died = 1'b0;
    level_cleared = 1'b0;
    st("died_and_clear", F_RESP, 2, 2, 1'b0);
    frame(); frame(); frame();
    st("boss_respawned", F_PLAY, 2, 2, 1'b0);
    pulse_clear();
    st("boss_win", F_WIN, 2, 2, 1'b0);
    pulse_clear();
    st("win_hold", F_WIN, 2, 2, 1'b0);
    key_on(ENTER);
    st("win_to_start", F_START, 2, 2, 1'b0);
    key_off();

    // Pause behaviour
    key_on(ENTER);
    key_off();
    key_on(ENTER);
    key_off();
    st("pause_setup", F_PLAY, 0, 3, 1'b0);
    key_on(ESC);
    st("esc_pause", F_PAUSE, 0, 3, 1'b0);
    clk1(); clk1(); clk1();
    st("esc_held", F_PAUSE, 0, 3, 1'b0);
    keycode = 8'h00;
    died = 1'b1;
    level_cleared = 1'b1;
    frame_tick = 1'b1;
    clk1();
    died = 1'b0;
    level_cleared = 1'b0;
    frame_tick = 1'b0;
    st("pause_ignores", F_PAUSE, 0, 3, 1'b0);
    key_on(ESC);
    st("esc_resume", F_PLAY, 0, 3, 1'b0);
    clk1(); clk1();
    st("esc_held_play", F_PLAY, 0, 3, 1'b0);
    key_off();

    // Async reset in the middle of respawn
    pulse_died();
    frame();
    st("pre_reset", F_RESP, 0, 2, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    st("async_reset", F_START, 0, 3, 1'b0);
    chk("async_reset.timer", 32'(dut.timer_q), 32'd0);
    clk1();
    Reset = 1'b0;
    clk1();
    st("post_reset", F_START, 0, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
